// File: rtl/mem_access_unit.sv
// Load/store unit: one core request at a time onto a valid/ready memory port.
// Define MEM_ACCESS_MISALIGN_SPLIT_EN to run word-crossing accesses as two bus beats.
module mem_access_unit #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  rsp_valid,
  output logic                  rsp_err,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W/8-1:0]   mem_wstrb,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata
);
  localparam int BYTES  = DATA_W / 8;
  localparam int LANE_W = $clog2(BYTES);
  localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
`ifdef MEM_ACCESS_MISALIGN_SPLIT_EN
  localparam int SPAN = 2;
`else
  localparam int SPAN = 1;
`endif

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUS  = 2'd1;
  localparam logic [1:0] BUS2 = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  logic [1:0]          state_reg;
  logic                we_reg;
  logic                signed_reg;
  logic                err_reg;
  logic [1:0]          size_reg;
  logic [LANE_W-1:0]   lane_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic                mem_valid_reg;
  logic [ADDR_W-1:0]   mem_addr_reg;
  logic [BYTES-1:0]    mem_wstrb_reg;
  logic [DATA_W-1:0]   mem_wdata_reg;
  logic [DATA_W-1:0]   rdata_lo_reg;
`ifdef MEM_ACCESS_MISALIGN_SPLIT_EN
  logic                split_reg;
  logic [BYTES-1:0]    wstrb2_reg;
  logic [DATA_W-1:0]   wdata2_reg;
  logic [DATA_W-1:0]   rdata_hi_reg;
`endif

  // Request decode: lanes touched may spill into the next word when split is enabled.
  int                       lane_i;
  int                       nbytes;
  logic                     size_ok;
  logic                     crosses;
  logic [SPAN*BYTES-1:0]    strb_wide;
  logic [SPAN*DATA_W-1:0]   data_wide;

  always_comb begin
    lane_i    = int'(req_addr[LANE_W-1:0]);
    nbytes    = 1 << req_size;
    size_ok   = int'(req_size) <= LANE_W;
    crosses   = (lane_i + nbytes) > BYTES;
    strb_wide = '0;
    for (int b = 0; b < SPAN*BYTES; b++) begin
      strb_wide[b] = (b >= lane_i) && (b < lane_i + nbytes);
    end
    data_wide = (SPAN*DATA_W)'(req_wdata) << (8 * lane_i);
  end

  logic tmo_hit;
  assign tmo_hit = (TIMEOUT != 0) && (int'(cnt_reg) == TIMEOUT - 1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= IDLE;
      we_reg        <= 1'b0;
      signed_reg    <= 1'b0;
      err_reg       <= 1'b0;
      size_reg      <= '0;
      lane_reg      <= '0;
      cnt_reg       <= '0;
      mem_valid_reg <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wstrb_reg <= '0;
      mem_wdata_reg <= '0;
      rdata_lo_reg  <= '0;
`ifdef MEM_ACCESS_MISALIGN_SPLIT_EN
      split_reg     <= 1'b0;
      wstrb2_reg    <= '0;
      wdata2_reg    <= '0;
      rdata_hi_reg  <= '0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            we_reg        <= req_we;
            signed_reg    <= req_signed;
            size_reg      <= req_size;
            lane_reg      <= req_addr[LANE_W-1:0];
            err_reg       <= 1'b0;
            cnt_reg       <= '0;
            mem_addr_reg  <= {req_addr[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
            mem_wstrb_reg <= req_we ? strb_wide[BYTES-1:0] : '0;
            mem_wdata_reg <= req_we ? data_wide[DATA_W-1:0] : '0;
`ifdef MEM_ACCESS_MISALIGN_SPLIT_EN
            split_reg     <= size_ok && crosses;
            wstrb2_reg    <= req_we ? strb_wide[2*BYTES-1:BYTES] : '0;
            wdata2_reg    <= req_we ? data_wide[2*DATA_W-1:DATA_W] : '0;
            if (!size_ok) begin
              err_reg   <= 1'b1;
              state_reg <= RESP;
            end else begin
              mem_valid_reg <= 1'b1;
              state_reg     <= BUS;
            end
`else
            if (!size_ok || crosses) begin
              err_reg   <= 1'b1;
              state_reg <= RESP;
            end else begin
              mem_valid_reg <= 1'b1;
              state_reg     <= BUS;
            end
`endif
          end
        end
`ifdef MEM_ACCESS_MISALIGN_SPLIT_EN
        BUS, BUS2: begin
`else
        BUS: begin
`endif
          if (mem_valid_reg) begin
            if (mem_ready) begin
              mem_valid_reg <= 1'b0;
              cnt_reg       <= '0;
`ifdef MEM_ACCESS_MISALIGN_SPLIT_EN
              if (state_reg == BUS) begin
                rdata_lo_reg <= mem_rdata;
              end else begin
                rdata_hi_reg <= mem_rdata;
              end
              // Second beat re-asserts mem_valid one cycle later from the BUS2 arm below.
              if (split_reg && state_reg == BUS) begin
                mem_addr_reg  <= mem_addr_reg + ADDR_W'(BYTES);
                mem_wstrb_reg <= wstrb2_reg;
                mem_wdata_reg <= wdata2_reg;
                state_reg     <= BUS2;
              end else begin
                state_reg <= RESP;
              end
`else
              rdata_lo_reg <= mem_rdata;
              state_reg    <= RESP;
`endif
            end else if (tmo_hit) begin
              mem_valid_reg <= 1'b0;
              cnt_reg       <= '0;
              err_reg       <= 1'b1;
              state_reg     <= RESP;
            end else if (TIMEOUT != 0) begin
              cnt_reg <= cnt_reg + CNT_W'(1);
            end
          end else begin
            mem_valid_reg <= 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Load data path: shift captured lanes down, then extend per access size.
  logic [DATA_W-1:0] rd_raw;
  logic [DATA_W-1:0] ext [0:LANE_W];
  logic [DATA_W-1:0] rd_sel;

`ifdef MEM_ACCESS_MISALIGN_SPLIT_EN
  assign rd_raw = DATA_W'({rdata_hi_reg, rdata_lo_reg} >> (8 * int'(lane_reg)));
`else
  assign rd_raw = rdata_lo_reg >> (8 * int'(lane_reg));
`endif

  generate
    for (genvar gi = 0; gi <= LANE_W; gi++) begin : g_ext
      localparam int W = 8 << gi;
      if (W == DATA_W) begin : g_full
        assign ext[gi] = rd_raw;
      end else begin : g_part
        assign ext[gi] = {{(DATA_W-W){signed_reg & rd_raw[W-1]}}, rd_raw[W-1:0]};
      end
    end
  endgenerate

  always_comb begin
    rd_sel = '0;
    for (int s = 0; s <= LANE_W; s++) begin
      if (int'(size_reg) == s) begin
        rd_sel = ext[s];
      end
    end
  end

  assign req_ready = (state_reg == IDLE);
  assign rsp_valid = (state_reg == RESP);
  assign rsp_err   = (state_reg == RESP) && err_reg;
  assign rsp_rdata = ((state_reg == RESP) && !err_reg && !we_reg) ? rd_sel : '0;
  assign mem_valid = mem_valid_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wstrb = mem_wstrb_reg;
  assign mem_wdata = mem_wdata_reg;

endmodule
